rom_fetch_unit: RTL and testbench

- Read-side initiator for the instruction ROM. Word-aligned ROM, 1-cycle synchronous read latency, no stall or ready signal.
- Generates sequential fetch addresses and tracks the single in-flight read.
- Captures returned words into a small FIFO tagged with their PC, presented to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight instructions.

---
 rtl/rom_fetch_unit.sv | 107 ++++++++++
 tb/tb_rom_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
// Instruction ROM fetch unit: sequential address generation, single in-flight read
// tracking, PC-tagged instruction FIFO to decode, and redirect flush.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds a sticky fetch_fault output
// for misaligned redirects; without it, redirect targets are aligned down.
module rom_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        rom_enable,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);

  entry_t [DEPTH-1:0] fifo;
  logic [PTR_W-1:0]   wptr, rptr;
  logic [PTR_W:0]     count;
  logic [31:0]        fetch_pc;
  logic [31:0]        inflight_pc;
  logic               inflight;

  logic               issue, push, pop, halt;
  logic [PTR_W+1:0]   occ;
  logic [31:0]        redirect_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign halt         = fetch_fault;
  assign redirect_tgt = redirect_pc;
`else
  assign halt         = 1'b0;
  assign redirect_tgt = redirect_pc & ~32'h3;
`endif

  // Occupancy counts the in-flight read but not a same-cycle pop, so a push
  // can never land in a full FIFO. rst_n gating keeps the ROM idle in reset.
  assign occ   = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight};
  assign issue = rst_n && !redirect_valid && !halt && (occ < DEPTH_W);
  assign push  = inflight && !redirect_valid;
  assign pop   = instr_valid && instr_ready && !redirect_valid;

  assign rom_enable  = issue;
  assign rom_address = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_data  = fifo[rptr].data;
  assign instr_pc    = fifo[rptr].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      fifo        <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Redirect wins over everything: drop the buffered and in-flight words.
      fetch_pc <= redirect_tgt;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) fetch_fault <= 1'b1;
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) begin
        fifo[wptr] <= '{pc: inflight_pc, data: rom_data};
        wptr       <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit: per-cycle vector table plus an
// alternating-ready sequence checked against a small occupancy model.
module tb_rom_fetch_unit;

  logic        clk, rst_n, redirect_valid, instr_ready;
  logic [31:0] redirect_pc, rom_address, rom_data, instr_data, instr_pc;
  logic        rom_enable, instr_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int nchk = 0;
  int nerr = 0;

  rom_fetch_unit #(.RESET_PC(32'h100), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_enable(rom_enable), .rom_address(rom_address), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word i holds 0xA000_0000 + i, one-cycle read latency.
  initial rom_data = '0;
  always @(posedge clk)
    if (rom_enable) rom_data <= 32'hA000_0000 + (rom_address >> 2);

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] data;
    logic        flt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rd, input logic [31:0] rp, input logic y,
                     input logic e, input logic [31:0] a, input logic v,
                     input logic [31:0] p, input logic [31:0] d, input logic f);
    vec_t x;
    x.rst = r; x.redir = rd; x.rpc = rp; x.rdy = y;
    x.en = e; x.addr = a; x.vld = v; x.pc = p; x.data = d; x.flt = f;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int          cnt_m, infl_m;
  logic        pop_m, iss_m;
  logic [31:0] exp_pc;

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // A: ready high from reset, one instruction per cycle
    add(0,0,0,1, 0,32'h100,0,0,0,0);
    add(1,0,0,1, 1,32'h100,0,0,0,0);
    add(1,0,0,1, 1,32'h104,0,0,0,0);
    add(1,0,0,1, 1,32'h108,1,32'h100,32'hA000_0040,0);
    add(1,0,0,1, 1,32'h10C,1,32'h104,32'hA000_0041,0);
    add(1,0,0,1, 1,32'h110,1,32'h108,32'hA000_0042,0);
    // B: ready low from reset fills to 4, then drains in order
    add(0,0,0,0, 0,32'h100,0,0,0,0);
    add(1,0,0,0, 1,32'h100,0,0,0,0);
    add(1,0,0,0, 1,32'h104,0,0,0,0);
    add(1,0,0,0, 1,32'h108,1,32'h100,32'hA000_0040,0);
    add(1,0,0,0, 1,32'h10C,1,32'h100,32'hA000_0040,0);
    add(1,0,0,0, 0,32'h110,1,32'h100,32'hA000_0040,0);
    add(1,0,0,0, 0,32'h110,1,32'h100,32'hA000_0040,0);
    add(1,0,0,1, 0,32'h110,1,32'h100,32'hA000_0040,0);
    add(1,0,0,1, 1,32'h110,1,32'h104,32'hA000_0041,0);
    add(1,0,0,1, 1,32'h114,1,32'h108,32'hA000_0042,0);
    add(1,0,0,1, 1,32'h118,1,32'h10C,32'hA000_0043,0);
    add(1,0,0,1, 1,32'h11C,1,32'h110,32'hA000_0044,0);
    add(1,0,0,1, 1,32'h120,1,32'h114,32'hA000_0045,0);
    // C: redirect to 0x200 with 3 buffered + 1 in flight
    add(0,0,0,0, 0,32'h100,0,0,0,0);
    add(1,0,0,0, 1,32'h100,0,0,0,0);
    add(1,0,0,0, 1,32'h104,0,0,0,0);
    add(1,0,0,0, 1,32'h108,1,32'h100,32'hA000_0040,0);
    add(1,0,0,0, 1,32'h10C,1,32'h100,32'hA000_0040,0);
    add(1,1,32'h200,0, 0,32'h110,1,32'h100,32'hA000_0040,0);
    add(1,0,0,1, 1,32'h200,0,0,0,0);
    add(1,0,0,1, 1,32'h204,0,0,0,0);
    add(1,0,0,1, 1,32'h208,1,32'h200,32'hA000_0080,0);
    add(1,0,0,1, 1,32'h20C,1,32'h204,32'hA000_0081,0);
    // D: address wrap past 0xFFFF_FFFC (pop during redirect is ignored)
    add(1,1,32'hFFFF_FFF8,1, 0,32'h210,1,32'h208,32'hA000_0082,0);
    add(1,0,0,1, 1,32'hFFFF_FFF8,0,0,0,0);
    add(1,0,0,1, 1,32'hFFFF_FFFC,0,0,0,0);
    add(1,0,0,1, 1,32'h0,1,32'hFFFF_FFF8,32'hDFFF_FFFE,0);
    add(1,0,0,1, 1,32'h4,1,32'hFFFF_FFFC,32'hDFFF_FFFF,0);
    add(1,0,0,1, 1,32'h8,1,32'h0,32'hA000_0000,0);
    // E: back-to-back redirects, last wins
    add(1,1,32'h300,1, 0,32'hC,1,32'h4,32'hA000_0001,0);
    add(1,1,32'h400,1, 0,32'h300,0,0,0,0);
    add(1,0,0,1, 1,32'h400,0,0,0,0);
    add(1,0,0,1, 1,32'h404,0,0,0,0);
    add(1,0,0,1, 1,32'h408,1,32'h400,32'hA000_0100,0);
    // F: misaligned redirect
    add(1,1,32'h202,1, 0,32'h40C,1,32'h404,32'hA000_0101,0);
`ifdef FETCH_MISALIGN_CHECK_EN
    add(1,0,0,1, 0,32'h202,0,0,0,1);
    add(1,0,0,1, 0,32'h202,0,0,0,1);
    add(1,0,0,1, 0,32'h202,0,0,0,1);
`else
    add(1,0,0,1, 1,32'h200,0,0,0,0);
    add(1,0,0,1, 1,32'h204,0,0,0,0);
    add(1,0,0,1, 1,32'h208,1,32'h200,32'hA000_0080,0);
`endif
    // G: reset mid-operation, no stale push afterwards
    add(0,0,0,1, 0,32'h100,0,0,0,0);
    add(1,0,0,1, 1,32'h100,0,0,0,0);
    add(1,0,0,1, 1,32'h104,0,0,0,0);
    add(1,0,0,1, 1,32'h108,1,32'h100,32'hA000_0040,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst; redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc; instr_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d rom_enable", i), {31'b0, rom_enable}, {31'b0, tbl[i].en});
      chk($sformatf("row%0d rom_address", i), rom_address, tbl[i].addr);
      chk($sformatf("row%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].vld});
      if (tbl[i].vld || !tbl[i].rst) begin
        chk($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].pc);
        chk($sformatf("row%0d instr_data", i), instr_data, tbl[i].data);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      chk($sformatf("row%0d fetch_fault", i), {31'b0, fetch_fault}, {31'b0, tbl[i].flt});
`endif
    end

    // Alternating ready for 50 cycles against an occupancy model.
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0; infl_m = 0; exp_pc = 32'h100;
    for (int k = 0; k < 50; k++) begin
      instr_ready = (k % 2 == 0);
      #1;
      iss_m = (cnt_m + infl_m) < 4;
      pop_m = (cnt_m != 0) && instr_ready;
      chk($sformatf("alt%0d count", k), {29'b0, dut.count}, cnt_m);
      chk($sformatf("alt%0d rom_enable", k), {31'b0, rom_enable}, {31'b0, iss_m});
      chk($sformatf("alt%0d instr_valid", k), {31'b0, instr_valid}, {31'b0, cnt_m != 0});
      if (pop_m) begin
        chk($sformatf("alt%0d instr_pc", k), instr_pc, exp_pc);
        chk($sformatf("alt%0d instr_data", k), instr_data, 32'hA000_0000 + (exp_pc >> 2));
        exp_pc = exp_pc + 32'd4;
      end
      cnt_m  = cnt_m + infl_m - (pop_m ? 1 : 0);
      infl_m = iss_m ? 1 : 0;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
